drain_row_collector: RTL and testbench

// - Successor drain stage for the systolic array. Accepts skewed per-lane drain results

---
 rtl/drain_row_collector_pkg.sv | 27 ++
 rtl/drain_row_collector_if.sv | 33 +++
 rtl/drain_row_collector_lane_fifo.sv | 57 +++++
 rtl/drain_row_collector.sv | 139 +++++++++++++
 tb/tb_drain_row_collector.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/drain_row_collector_pkg.sv
// Shared types for the systolic-array drain stage.
// Element type, pairing mode, row index and lane/width helpers.
package drain_row_collector_pkg;

    localparam int SYS_ARRAY_SIZE = 4;
    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        DRAIN_SINGLE = 1'b0,
        DRAIN_PAIRED = 1'b1
    } drain_mode_e;

    localparam int IDX_W = (SYS_ARRAY_SIZE > 1) ? $clog2(SYS_ARRAY_SIZE) : 1;

    typedef logic [IDX_W-1:0] row_idx_t;

    function automatic int lane_count(input int n, input int paired);
        return (paired != 0) ? (n + 1) / 2 : n;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/drain_row_collector_if.sv
// Lane drain inputs, array back-pressure and the row output handshake.
// master = array/memory side, slave = the collector.
interface drain_row_collector_if
    import drain_row_collector_pkg::*;
#(
    parameter int N      = SYS_ARRAY_SIZE,
    parameter int PAIRED = 1
);

    localparam int L  = lane_count(N, PAIRED);
    localparam int IW = idx_width(N);

    logic [L-1:0]  lane_valid;
    data_t [L-1:0] array_data;
    logic          stall;
    logic          row_valid;
    logic          row_ready;
    data_t [N-1:0] row_data;
    logic [IW-1:0] row_idx;
    logic          row_last;
    logic          overflow;

    modport master (
        output lane_valid, array_data, row_ready,
        input  stall, row_valid, row_data, row_idx, row_last, overflow
    );

    modport slave (
        input  lane_valid, array_data, row_ready,
        output stall, row_valid, row_data, row_idx, row_last, overflow
    );

endinterface

// File: rtl/drain_row_collector_lane_fifo.sv
// Per-lane deskew FIFO; a push on a full FIFO is taken only
// when the same cycle also pops.
module drain_row_collector_lane_fifo
    import drain_row_collector_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  data_t                      din,
    output data_t                      dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    data_t         mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/drain_row_collector.sv
// Drain stage: deskews per-lane array results and emits full
// matrix rows on a valid/ready port with stall back-pressure.
module drain_row_collector
    import drain_row_collector_pkg::*;
#(
    parameter int N            = SYS_ARRAY_SIZE,
    parameter int PAIRED       = 1,
    parameter int DEPTH        = 4,
    parameter int STALL_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    drain_row_collector_if.slave bus
);

    localparam int L  = lane_count(N, PAIRED);
    localparam int IW = idx_width(N);
    localparam int CW = $clog2(DEPTH + 1);
    localparam drain_mode_e MODE = (PAIRED != 0) ? DRAIN_PAIRED : DRAIN_SINGLE;
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - STALL_MARGIN);

    data_t [L-1:0] lane_dout;
    logic [L-1:0]  lane_empty;
    logic [L-1:0]  lane_full;
    logic [CW-1:0] lane_cnt [L];
    logic [L-1:0]  lane_hi;
    logic [L-1:0]  lane_drop;

    logic          all_ready;
    logic          out_free;
    logic          row_fire;
    logic          beat_pop;
    logic          load_out;
    data_t [N-1:0] row_asm;

    logic          row_valid_q;
    data_t [N-1:0] row_q;
    logic [IW-1:0] idx_q;
    logic          stall_q;
    logic          ovf_q;

    for (genvar z = 0; z < L; z++) begin : g_lane
        logic          push_ok;
        logic [CW-1:0] cnt_nxt;

        drain_row_collector_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear),
            .push  (bus.lane_valid[z]),
            .pop   (beat_pop),
            .din   (bus.array_data[z]),
            .dout  (lane_dout[z]),
            .empty (lane_empty[z]),
            .full  (lane_full[z]),
            .count (lane_cnt[z])
        );

        assign push_ok      = bus.lane_valid[z] && (!lane_full[z] || beat_pop);
        assign cnt_nxt      = lane_cnt[z] + CW'(push_ok) - CW'(beat_pop);
        assign lane_hi[z]   = (cnt_nxt >= STALL_LVL);
        assign lane_drop[z] = bus.lane_valid[z] && lane_full[z] && !beat_pop;
    end

    assign all_ready = ~|lane_empty;
    assign out_free  = !row_valid_q || bus.row_ready;
    assign row_fire  = row_valid_q && bus.row_ready;

    if (MODE == DRAIN_PAIRED) begin : g_paired
        logic          half_full;
        data_t [L-1:0] half_q;

        // The even-column beat only needs the half register.
        assign beat_pop = all_ready && (!half_full || out_free);
        assign load_out = beat_pop && half_full;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                half_full <= 1'b0;
                half_q    <= '0;
            end else if (clear) begin
                half_full <= 1'b0;
                half_q    <= '0;
            end else if (beat_pop) begin
                half_full <= !half_full;
                if (!half_full) half_q <= lane_dout;
            end
        end

        for (genvar c = 0; c < N; c++) begin : g_col
            if (c % 2 == 0) begin : g_even
                assign row_asm[c] = half_q[c/2];
            end else begin : g_odd
                assign row_asm[c] = lane_dout[c/2];
            end
        end
    end else begin : g_single
        assign beat_pop = all_ready && out_free;
        assign load_out = beat_pop;
        assign row_asm  = lane_dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_valid_q <= 1'b0;
            row_q       <= '0;
            idx_q       <= '0;
            stall_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (clear) begin
            row_valid_q <= 1'b0;
            row_q       <= '0;
            idx_q       <= '0;
            stall_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (load_out) begin
                row_valid_q <= 1'b1;
                row_q       <= row_asm;
            end else if (row_fire) begin
                row_valid_q <= 1'b0;
            end
            if (row_fire) begin
                idx_q <= (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
            end
            stall_q <= |lane_hi;
            if (|lane_drop) ovf_q <= 1'b1;
        end
    end

    assign bus.row_valid = row_valid_q;
    assign bus.row_data  = row_q;
    assign bus.row_idx   = idx_q;
    assign bus.row_last  = row_valid_q && (idx_q == IW'(N - 1));
    assign bus.stall     = stall_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_drain_row_collector.sv
// Scoreboard bench: single-column N=4, paired N=4 and paired N=3
// collectors, driven and sampled on the falling clock edge.
module tb_drain_row_collector;
    import drain_row_collector_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    int   vec = 0;
    int   err = 0;
    int   exp_idx_s = 0;

    logic [63:0] exp_q [$];
    logic [63:0] exp_row;

    always #5 clk = ~clk;

    drain_row_collector_if #(.N(4), .PAIRED(0)) if_s ();
    drain_row_collector_if #(.N(4), .PAIRED(1)) if_p ();
    drain_row_collector_if #(.N(3), .PAIRED(1)) if_o ();

    drain_row_collector #(.N(4), .PAIRED(0), .DEPTH(4), .STALL_MARGIN(2)) u_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_s.slave));
    drain_row_collector #(.N(4), .PAIRED(1), .DEPTH(4), .STALL_MARGIN(2)) u_p (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_p.slave));
    drain_row_collector #(.N(3), .PAIRED(1), .DEPTH(4), .STALL_MARGIN(2)) u_o (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_o.slave));

    function automatic logic [63:0] row4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        if_s.lane_valid = '0; if_s.array_data = '0; if_s.row_ready = 1'b0;
        if_p.lane_valid = '0; if_p.array_data = '0; if_p.row_ready = 1'b0;
        if_o.lane_valid = '0; if_o.array_data = '0; if_o.row_ready = 1'b0;
        repeat (3) @(negedge clk);
        vec++;
        if ({if_s.row_valid, if_s.row_idx, if_s.stall, if_s.overflow, if_s.row_data} !== '0) begin
            err++;
            $display("FAIL reset_s: got %h want 0",
                     {if_s.row_valid, if_s.row_idx, if_s.stall, if_s.overflow, if_s.row_data});
        end
        vec++;
        if ({if_p.row_valid, if_p.row_idx, if_p.stall, if_p.overflow, if_p.row_data} !== '0) begin
            err++;
            $display("FAIL reset_p: got %h want 0",
                     {if_p.row_valid, if_p.row_idx, if_p.stall, if_p.overflow, if_p.row_data});
        end
        rst_n = 1'b1;
        @(negedge clk);
        vec++;
        if ({if_o.row_valid, if_o.row_idx, if_o.stall, if_o.overflow, if_o.row_data} !== '0) begin
            err++;
            $display("FAIL reset_o: got %h want 0",
                     {if_o.row_valid, if_o.row_idx, if_o.stall, if_o.overflow, if_o.row_data});
        end
    endtask

    task automatic test_latency();
        logic [63:0] d;
        exp_q.delete();
        if_s.row_ready = 1'b1;
        exp_q.push_back(row4(10, 20, 30, 40));
        for (int k = 0; k < 4; k++) begin
            vec++;
            if (if_s.row_valid !== 1'b0) begin
                err++;
                $display("FAIL skew_early_valid k=%0d: got %b want 0", k, if_s.row_valid);
            end
            d = '0;
            d[k*16 +: 16] = 16'(10 * (k + 1));
            if_s.lane_valid = 4'(1 << k);
            if_s.array_data = d;
            @(negedge clk);
        end
        if_s.lane_valid = '0;
        vec++;
        if (if_s.row_valid !== 1'b0) begin
            err++;
            $display("FAIL latency_t1: got %b want 0", if_s.row_valid);
        end
        @(negedge clk);
        vec++;
        if (if_s.row_valid !== 1'b1) begin
            err++;
            $display("FAIL latency_t2: got %b want 1", if_s.row_valid);
        end
        if (if_s.row_valid && exp_q.size() > 0) begin
            exp_row = exp_q.pop_front();
            vec++;
            if (if_s.row_data !== exp_row) begin
                err++;
                $display("FAIL skew_row: got %h want %h", if_s.row_data, exp_row);
            end
            vec++;
            if (if_s.row_idx !== 2'(exp_idx_s)) begin
                err++;
                $display("FAIL skew_idx: got %0d want %0d", if_s.row_idx, exp_idx_s);
            end
            exp_idx_s = (exp_idx_s + 1) % 4;
        end
        @(negedge clk);
        if_s.row_ready = 1'b0;
    endtask

    task automatic test_paired();
        bit got_p = 0;
        bit got_o = 0;
        exp_q.delete();
        if_p.row_ready = 1'b1;
        if_o.row_ready = 1'b1;
        if_p.lane_valid = 2'b11; if_p.array_data = {16'd3, 16'd1};
        if_o.lane_valid = 2'b11; if_o.array_data = {16'd3, 16'd1};
        @(negedge clk);
        if_p.lane_valid = '0;
        if_o.lane_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vec++;
            if (if_p.row_valid !== 1'b0 || if_o.row_valid !== 1'b0) begin
                err++;
                $display("FAIL half_beat_only: got %b%b want 00", if_p.row_valid, if_o.row_valid);
            end
        end
        exp_q.push_back(row4(1, 2, 3, 4));
        exp_q.push_back(row4(1, 2, 3, 0));
        if_p.lane_valid = 2'b11; if_p.array_data = {16'd4, 16'd2};
        if_o.lane_valid = 2'b11; if_o.array_data = {16'd99, 16'd2};
        @(negedge clk);
        if_p.lane_valid = '0;
        if_o.lane_valid = '0;
        for (int c = 0; c < 8 && !(got_p && got_o); c++) begin
            if (!got_p && if_p.row_valid && if_p.row_ready) begin
                got_p = 1;
                exp_row = exp_q.pop_front();
                vec++;
                if (64'(if_p.row_data) !== exp_row) begin
                    err++;
                    $display("FAIL paired_row_n4: got %h want %h", if_p.row_data, exp_row);
                end
            end
            if (!got_o && if_o.row_valid && if_o.row_ready) begin
                got_o = 1;
                exp_row = exp_q.pop_front();
                vec++;
                if (64'(if_o.row_data) !== exp_row) begin
                    err++;
                    $display("FAIL paired_row_n3: got %h want %h", if_o.row_data, exp_row);
                end
                vec++;
                if (if_o.row_last !== 1'b0) begin
                    err++;
                    $display("FAIL paired_last_n3: got %b want 0", if_o.row_last);
                end
            end
            @(negedge clk);
        end
        if (!got_p || !got_o) begin
            vec++;
            err++;
            $display("FAIL paired_timeout: got %b%b want 11", got_p, got_o);
        end
        if_p.row_ready = 1'b0;
        if_o.row_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [63:0] r0;
        int n = 0;
        exp_q.delete();
        if_s.row_ready = 1'b0;
        r0 = row4(100, 101, 102, 103);
        for (int k = 0; k < 4; k++) begin
            exp_row = row4(100 * (k + 1), 100 * (k + 1) + 1, 100 * (k + 1) + 2, 100 * (k + 1) + 3);
            exp_q.push_back(exp_row);
            if_s.lane_valid = 4'hF;
            if_s.array_data = exp_row;
            @(negedge clk);
            vec++;
            if (if_s.stall !== (k >= 2)) begin
                err++;
                $display("FAIL stall_rise k=%0d: got %b want %b", k, if_s.stall, k >= 2);
            end
            vec++;
            if (if_s.overflow !== 1'b0) begin
                err++;
                $display("FAIL stall_no_ovf k=%0d: got %b want 0", k, if_s.overflow);
            end
            if (k >= 1) begin
                vec++;
                if (if_s.row_valid !== 1'b1 || if_s.row_data !== r0) begin
                    err++;
                    $display("FAIL hold_stable k=%0d: got %b/%h want 1/%h", k, if_s.row_valid, if_s.row_data, r0);
                end
            end
        end
        if_s.lane_valid = '0;
        repeat (3) @(negedge clk);
        vec++;
        if (if_s.row_data !== r0 || if_s.stall !== 1'b1) begin
            err++;
            $display("FAIL hold_idle: got %h/%b want %h/1", if_s.row_data, if_s.stall, r0);
        end
        if_s.row_ready = 1'b1;
        for (int c = 0; c < 12 && n < 4; c++) begin
            if (if_s.row_valid && if_s.row_ready) begin
                n++;
                exp_row = exp_q.pop_front();
                vec++;
                if (if_s.row_data !== exp_row || if_s.row_idx !== 2'(exp_idx_s)) begin
                    err++;
                    $display("FAIL stall_drain row%0d: got %h idx %0d want %h idx %0d",
                             n, if_s.row_data, if_s.row_idx, exp_row, exp_idx_s);
                end
                exp_idx_s = (exp_idx_s + 1) % 4;
            end
            @(negedge clk);
        end
        vec++;
        if (n != 4 || if_s.stall !== 1'b0) begin
            err++;
            $display("FAIL stall_drain_end: got %0d rows stall %b want 4 rows stall 0", n, if_s.stall);
        end
        if_s.row_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int n = 0;
        exp_q.delete();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_idx_s = 0;
        if_s.row_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_row = row4(200 + 10 * k, 201 + 10 * k, 202 + 10 * k, 203 + 10 * k);
            exp_q.push_back(exp_row);
            if_s.lane_valid = 4'hF;
            if_s.array_data = exp_row;
            @(negedge clk);
        end
        vec++;
        if (if_s.overflow !== 1'b0) begin
            err++;
            $display("FAIL fill_no_ovf: got %b want 0", if_s.overflow);
        end
        // Full FIFO: push and pop in the same cycle.
        exp_row = row4(250, 251, 252, 253);
        exp_q.push_back(exp_row);
        if_s.array_data = exp_row;
        if_s.row_ready = 1'b1;
        if (if_s.row_valid) begin
            exp_row = exp_q.pop_front();
            exp_idx_s = (exp_idx_s + 1) % 4;
            vec++;
            if (if_s.row_data !== exp_row) begin
                err++;
                $display("FAIL pushpop_row: got %h want %h", if_s.row_data, exp_row);
            end
        end
        @(negedge clk);
        if_s.row_ready = 1'b0;
        vec++;
        if (if_s.overflow !== 1'b0) begin
            err++;
            $display("FAIL pushpop_no_ovf: got %b want 0", if_s.overflow);
        end
        if_s.array_data = row4(999, 999, 999, 999);
        @(negedge clk);
        if_s.lane_valid = '0;
        vec++;
        if (if_s.overflow !== 1'b1) begin
            err++;
            $display("FAIL ovf_set: got %b want 1", if_s.overflow);
        end
        repeat (2) @(negedge clk);
        if_s.row_ready = 1'b1;
        for (int c = 0; c < 14 && n < 5; c++) begin
            if (if_s.row_valid && if_s.row_ready) begin
                n++;
                exp_row = exp_q.pop_front();
                vec++;
                if (if_s.row_data !== exp_row || if_s.row_idx !== 2'(exp_idx_s)) begin
                    err++;
                    $display("FAIL ovf_drain row%0d: got %h idx %0d want %h idx %0d",
                             n, if_s.row_data, if_s.row_idx, exp_row, exp_idx_s);
                end
                exp_idx_s = (exp_idx_s + 1) % 4;
            end
            @(negedge clk);
        end
        vec++;
        if (n != 5 || if_s.row_valid !== 1'b0 || if_s.overflow !== 1'b1) begin
            err++;
            $display("FAIL ovf_sticky_end: got %0d rows valid %b ovf %b want 5 rows valid 0 ovf 1",
                     n, if_s.row_valid, if_s.overflow);
        end
        if_s.row_ready = 1'b0;
    endtask

    task automatic test_row_index();
        int want_idx [5] = '{0, 1, 2, 3, 0};
        int n = 0;
        exp_q.delete();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        vec++;
        if (if_s.overflow !== 1'b0 || if_s.row_idx !== 2'd0) begin
            err++;
            $display("FAIL clear_s: got ovf %b idx %0d want 0 0", if_s.overflow, if_s.row_idx);
        end
        if_s.row_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_row = row4(k + 1, k + 2, k + 3, 1000 + k);
            exp_q.push_back(exp_row);
            if_s.lane_valid = 4'hF;
            if_s.array_data = exp_row;
            @(negedge clk);
        end
        if_s.lane_valid = '0;
        if_s.row_ready = 1'b1;
        for (int c = 0; c < 14 && n < 5; c++) begin
            if (if_s.row_valid && if_s.row_ready) begin
                exp_row = exp_q.pop_front();
                vec++;
                if (if_s.row_data !== exp_row) begin
                    err++;
                    $display("FAIL idx_row%0d_data: got %h want %h", n, if_s.row_data, exp_row);
                end
                vec++;
                if (if_s.row_idx !== 2'(want_idx[n]) || if_s.row_last !== (want_idx[n] == 3)) begin
                    err++;
                    $display("FAIL idx_row%0d: got idx %0d last %b want idx %0d last %b",
                             n, if_s.row_idx, if_s.row_last, want_idx[n], want_idx[n] == 3);
                end
                n++;
            end
            @(negedge clk);
        end
        if (n != 5) begin
            vec++;
            err++;
            $display("FAIL idx_timeout: got %0d rows want 5", n);
        end
        if_s.row_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] beats [5];
        bit got;
        beats = '{{16'd3, 16'd1}, {16'd4, 16'd2}, {16'd7, 16'd5}, {16'd8, 16'd6}, {16'd11, 16'd9}};
        for (int ph = 0; ph < 2; ph++) begin
            exp_q.delete();
            if_p.row_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if_p.lane_valid = 2'b11;
                if_p.array_data = beats[k];
                @(negedge clk);
            end
            if_p.lane_valid = '0;
            vec++;
            if (if_p.row_valid !== 1'b1 || 64'(if_p.row_data) !== row4(1, 2, 3, 4) || if_p.stall !== 1'b1) begin
                err++;
                $display("FAIL pending_ph%0d: got %b %h %b want 1 %h 1",
                         ph, if_p.row_valid, if_p.row_data, if_p.stall, row4(1, 2, 3, 4));
            end
            if (ph == 0) begin
                #2 rst_n = 1'b0;
                #1;
                vec++;
                if ({if_p.row_valid, if_p.row_idx, if_p.stall, if_p.overflow, if_p.row_data} !== '0) begin
                    err++;
                    $display("FAIL async_reset: got %h want 0",
                             {if_p.row_valid, if_p.row_idx, if_p.stall, if_p.overflow, if_p.row_data});
                end
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                clear = 1'b1;
                if_p.row_ready = 1'b1;
                if_p.lane_valid = 2'b11;
                if_p.array_data = {16'd77, 16'd77};
                @(negedge clk);
                clear = 1'b0;
                if_p.row_ready = 1'b0;
                if_p.lane_valid = '0;
                vec++;
                if ({if_p.row_valid, if_p.row_idx, if_p.stall, if_p.overflow, if_p.row_data} !== '0) begin
                    err++;
                    $display("FAIL sync_clear: got %h want 0",
                             {if_p.row_valid, if_p.row_idx, if_p.stall, if_p.overflow, if_p.row_data});
                end
            end
            exp_q.push_back(row4(11, 12, 13, 14));
            if_p.row_ready = 1'b1;
            if_p.lane_valid = 2'b11;
            if_p.array_data = {16'd13, 16'd11};
            @(negedge clk);
            if_p.array_data = {16'd14, 16'd12};
            @(negedge clk);
            if_p.lane_valid = '0;
            got = 0;
            for (int c = 0; c < 8 && !got; c++) begin
                if (if_p.row_valid && if_p.row_ready) begin
                    got = 1;
                    exp_row = exp_q.pop_front();
                    vec++;
                    if (64'(if_p.row_data) !== exp_row || if_p.row_idx !== 2'd0) begin
                        err++;
                        $display("FAIL fresh_row_ph%0d: got %h idx %0d want %h idx 0",
                                 ph, if_p.row_data, if_p.row_idx, exp_row);
                    end
                end
                @(negedge clk);
            end
            if (!got) begin
                vec++;
                err++;
                $display("FAIL fresh_timeout_ph%0d: got no row want one", ph);
            end
            if_p.row_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_paired();
        test_stall();
        test_overflow();
        test_row_index();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

endmodule
